selecting_machine_ctrl: RTL
===========================

// Module: selecting_machine_ctrl
// PURPOSE
//  Top-level sequencer for the selecting machine. Runs the power-on lamp test,
//  then waits for start. It then drives the seven per-digit run enables, flag[6:0],
//  that feed sequencer_chi/eng/num: 6 = lattice character, 5 = letter, 4..0 = digits.
//  Stop buttons take effect only in strict order 6..0. A stalled player is
//  auto-stopped after a timeout. The block replaces flag_control and the startup counter.
// PARAMETERS
//  TICK_DIV       12500000  clk cycles per tick (2 Hz at 25 MHz-equivalent scan timing)
//  BLINK_TOGGLES  6         startup_on toggles before leaving STARTUP (1..15)
//  TIMEOUT_TICKS  20        ticks without an accepted stop before auto-stop (1..255)
// PORTS
//  clk          in   1  system clock
//  rst          in   1  asynchronous, active-low reset
//  start_pulse  in   1  debounced 1-cycle start request (BTN_7 path)
//  stop_pulse   in   7  debounced 1-cycle stop requests; bit i stops channel i
//  flag         out  7  run enable per channel; 1 = counting, 0 = frozen
//  startup_on   out  1  1 = force all lattice/segment outputs lit (lamp test)
//  phase        out  2  0 STARTUP, 1 READY, 2 RUN, 3 DONE
//  next_ch      out  3  channel whose stop is accepted next (6..0), valid in RUN
//  auto_stop    out  1  1-cycle pulse: the timeout stopped next_ch
//  order_err    out  1  1-cycle pulse: out-of-order or redundant stop press
//  done         out  1  level, 1 while phase==DONE
// BEHAVIOUR
//  Reset (rst=0, async): phase=STARTUP, flag=7'h00, startup_on=1, next_ch=6,
//   auto_stop=0, order_err=0, done=0, tick and timeout counters = 0.
//  Tick: counter counts 0..TICK_DIV-1; tick pulses 1 cycle when it reaches TICK_DIV-1.
//   The counter clears on every phase change and on every accepted stop/auto-stop.
//  All outputs are registered. An event sampled at edge N is visible after edge N.
//  STARTUP: on each tick, toggle startup_on and increment the blink count.
//   On the tick that makes the count equal BLINK_TOGGLES: go to READY, startup_on=0.
//   start_pulse and stop_pulse are ignored; flag=0.
//  READY: flag=0. start_pulse -> RUN, flag=7'h7F, next_ch=6, timeout count=0.
//  RUN: a stop_pulse with bit[next_ch]=1 is accepted:
//   - clear flag[next_ch];
//   - decrement next_ch;
//   - clear the timeout count.
//   Any other set bit in stop_pulse (already-stopped or future channel) -> order_err=1
//   for one cycle. That bit is ignored. This also applies in the same cycle as an
//   accepted stop.
//   Timeout count +1 per tick. Reaching TIMEOUT_TICKS acts as an accepted stop and
//   pulses auto_stop. If a valid press and the timeout land on the same cycle, the press
//   wins: one channel stops and auto_stop=0.
//   Accepting channel 0 -> DONE in the same edge: flag=0, done=1.
//   start_pulse is ignored in RUN.
//  DONE: flag held 0, so sequencer codes freeze as the result.
//   start_pulse -> RUN as from READY (flag=7'h7F, next_ch=6). stop_pulse is ignored
//   and gives no order_err.
//  next_ch wraps to 6 only via re-entry to RUN; it never decrements below 0.
//  order_err is 0 outside RUN.
//  Mid-operation reset returns to STARTUP with the lamp test repeated.
//  The debounce/sequencer resets downstream are the integrator's responsibility.
// STRUCTURE
//  Package selecting_machine_pkg:
//   - phase codes PH_STARTUP/PH_READY/PH_RUN/PH_DONE (2-bit);
//   - NCH=7;
//   - FLAG_ALL_RUN=7'h7F.
//  Sub-module sm_tick_gen: params TICK_DIV; ports clk, rst, clr, tick.
//   Used for the startup blink and the timeout.
//  The remainder is a single FSM with blink count, timeout count, next_ch and flag registers.
// TESTING (bench params TICK_DIV=4, BLINK_TOGGLES=6, TIMEOUT_TICKS=3)
//  1. Release reset, no inputs -> startup_on toggles every 4 clk, 6 times.
//     Then phase=1, startup_on=0, flag=00.
//  2. In READY, start_pulse -> next cycle phase=2, flag=7F, next_ch=6.
//     Then stops 6,5,4,3,2,1,0 in order -> flag steps 3F,1F,0F,07,03,01,00,
//     then phase=3, done=1.
//  3. In RUN with next_ch=6, stop_pulse=7'h01 -> order_err 1 cycle, flag stays 7F.
//     Next, stop_pulse=7'h41 -> flag=3F, order_err=1.
//  4. In RUN, no presses for 12 clk -> auto_stop pulse, flag=3F, next_ch=5.
//     Presses landing on the timeout cycle -> one stop only, auto_stop=0.
//  5. In DONE, stop_pulse=7'h7F -> no change, no order_err.
//     Then start_pulse -> phase=2, flag=7F, next_ch=6.
//  6. Assert rst mid-RUN (flag=1F) -> immediately phase=0, flag=00, startup_on=1.
//     The lamp test reruns after release.

Source files
------------

// File: rtl/selecting_machine_pkg.sv
// Shared definitions for the selecting machine controller: phase codes,
// channel count and a channel-select helper.
package selecting_machine_pkg;

  typedef enum logic [1:0] {
    PH_STARTUP = 2'd0,
    PH_READY   = 2'd1,
    PH_RUN     = 2'd2,
    PH_DONE    = 2'd3
  } phase_e;

  localparam int NCH = 7;
  localparam logic [NCH-1:0] FLAG_ALL_RUN = 7'h7F;
  localparam logic [2:0] CH_FIRST = 3'd6;

  function automatic logic [NCH-1:0] ch_mask(input logic [2:0] ch);
    ch_mask = 7'b000_0001 << ch;
  endfunction

endpackage

// File: rtl/selecting_machine_ctrl_if.sv
// Control/status bundle between the front panel debouncers and the selecting
// machine sequencer; master drives the buttons, slave is the controller.
interface selecting_machine_ctrl_if;
  import selecting_machine_pkg::*;

  logic           start_pulse;
  logic [NCH-1:0] stop_pulse;
  logic [NCH-1:0] flag;
  logic           startup_on;
  logic [1:0]     phase;
  logic [2:0]     next_ch;
  logic           auto_stop;
  logic           order_err;
  logic           done;

  modport master (
    output start_pulse, stop_pulse,
    input  flag, startup_on, phase, next_ch, auto_stop, order_err, done
  );

  modport slave (
    input  start_pulse, stop_pulse,
    output flag, startup_on, phase, next_ch, auto_stop, order_err, done
  );

endinterface

// File: rtl/selecting_machine_ctrl_tick.sv
// Tick divider: one-cycle tick every TICK_DIV clocks, restartable via clr so
// blink and timeout intervals always start from a fresh count.
module sm_tick_gen #(
  parameter int TICK_DIV = 12500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_r;

  // Divider count, wrapping at LAST and restarting on clr
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (clr || (cnt_r == LAST)) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + ONE;
    end
  end

  assign tick = (cnt_r == LAST);

endmodule

// File: rtl/selecting_machine_ctrl.sv
// Selecting machine sequencer: lamp test, start, strictly ordered stops 6..0
// with per-player timeout, and the per-channel run enables.
module selecting_machine_ctrl
  import selecting_machine_pkg::*;
#(
  parameter int TICK_DIV      = 12500000,
  parameter int BLINK_TOGGLES = 6,
  parameter int TIMEOUT_TICKS = 20
) (
  input logic                     clk,
  input logic                     rst,
  selecting_machine_ctrl_if.slave bus
);

  phase_e         state_r,      state_nx;
  logic [NCH-1:0] flag_r,       flag_nx;
  logic           startup_on_r, startup_on_nx;
  logic [2:0]     next_ch_r,    next_ch_nx;
  logic           auto_stop_r,  auto_stop_nx;
  logic           order_err_r,  order_err_nx;
  logic           done_r,       done_nx;
  logic [3:0]     blink_r,      blink_nx;
  logic [7:0]     tout_r,       tout_nx;

  logic           tick_s;
  logic           clr_s;
  logic           accept_s;
  logic           press_ok_s;
  logic           tout_hit_s;
  logic [NCH-1:0] sel_s;

  sm_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_s),
    .tick (tick_s)
  );

  // Next-state and output decode for the sequencer FSM
  always_comb begin
    state_nx      = state_r;
    flag_nx       = flag_r;
    startup_on_nx = startup_on_r;
    next_ch_nx    = next_ch_r;
    blink_nx      = blink_r;
    tout_nx       = tout_r;
    auto_stop_nx  = 1'b0;
    order_err_nx  = 1'b0;
    accept_s      = 1'b0;
    sel_s         = ch_mask(next_ch_r);
    press_ok_s    = |(bus.stop_pulse & sel_s);
    tout_hit_s    = tick_s && (tout_r == 8'(TIMEOUT_TICKS - 1));

    case (state_r)
      PH_STARTUP: begin
        flag_nx = '0;
        if (tick_s) begin
          blink_nx = blink_r + 4'd1;
          if ((blink_r + 4'd1) == 4'(BLINK_TOGGLES)) begin
            state_nx      = PH_READY;
            startup_on_nx = 1'b0;
          end else begin
            startup_on_nx = ~startup_on_r;
          end
        end else begin
          blink_nx = blink_r;
        end
      end
      PH_READY, PH_DONE: begin
        flag_nx = '0;
        if (bus.start_pulse) begin
          state_nx   = PH_RUN;
          flag_nx    = FLAG_ALL_RUN;
          next_ch_nx = CH_FIRST;
          tout_nx    = 8'd0;
        end else begin
          tout_nx = tout_r;
        end
      end
      PH_RUN: begin
        // Only the expected channel may stop; every other set bit is flagged
        order_err_nx = |(bus.stop_pulse & ~sel_s);
        if (press_ok_s || tout_hit_s) begin
          accept_s     = 1'b1;
          auto_stop_nx = ~press_ok_s;
          flag_nx      = flag_r & ~sel_s;
          tout_nx      = 8'd0;
          if (next_ch_r == 3'd0) begin
            state_nx = PH_DONE;
            flag_nx  = '0;
          end else begin
            next_ch_nx = next_ch_r - 3'd1;
          end
        end else if (tick_s) begin
          tout_nx = tout_r + 8'd1;
        end else begin
          tout_nx = tout_r;
        end
      end
      default: begin
        state_nx = PH_STARTUP;
        flag_nx  = '0;
      end
    endcase

    done_nx = (state_nx == PH_DONE);
    clr_s   = accept_s || (state_nx != state_r);
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= PH_STARTUP;
      flag_r       <= '0;
      startup_on_r <= 1'b1;
      next_ch_r    <= CH_FIRST;
      auto_stop_r  <= 1'b0;
      order_err_r  <= 1'b0;
      done_r       <= 1'b0;
      blink_r      <= 4'd0;
      tout_r       <= 8'd0;
    end else begin
      state_r      <= state_nx;
      flag_r       <= flag_nx;
      startup_on_r <= startup_on_nx;
      next_ch_r    <= next_ch_nx;
      auto_stop_r  <= auto_stop_nx;
      order_err_r  <= order_err_nx;
      done_r       <= done_nx;
      blink_r      <= blink_nx;
      tout_r       <= tout_nx;
    end
  end

  assign bus.flag       = flag_r;
  assign bus.startup_on = startup_on_r;
  assign bus.phase      = state_r;
  assign bus.next_ch    = next_ch_r;
  assign bus.auto_stop  = auto_stop_r;
  assign bus.order_err  = order_err_r;
  assign bus.done       = done_r;

endmodule
